// File: rtl/spi_arbiter_pkg.sv
// Shared types and default sizing for the SPI requester arbiter.
package spi_arb_pkg;

    localparam int unsigned NUM_REQ_DEF     = 4;
    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin winner: first asserted request at or after rr_ptr, wrapping.
module spi_rr_picker
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between NUM_REQ requesters with round-robin fairness.
// Define SPI_ARB_TIMEOUT_EN to add the BUSY watchdog and the timeout_err port.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
`ifdef SPI_ARB_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
`endif
    localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_tx_data,
    input  logic [DATA_W-1:0]         spi_rx_data,
    input  logic                      spi_done,
    input  logic                      spi_ss_n,
    output logic [NUM_REQ-1:0]        slv_ss_n
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    spi_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            spi_tx_data <= '0;
            rsp_data    <= '0;
            ack         <= '0;
            spi_start   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ack       <= '0;
            spi_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id    <= pick_idx;
                        spi_tx_data <= req_data[32'(pick_idx)*DATA_W +: DATA_W];
                        spi_start   <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state  <= BUSY;
                end
                BUSY: begin
                    // ack is registered here so it is high exactly during DONE
                    if (spi_done) begin
                        rsp_data       <= spi_rx_data;
                        ack[grant_id]  <= 1'b1;
                        state          <= DONE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_data       <= '1;
                        ack[grant_id]  <= 1'b1;
                        timeout_err    <= 1'b1;
                        state          <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    rr_ptr <= IDX_W'((32'(grant_id) + 1) % NUM_REQ);
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        slv_ss_n = '1;
        if (state != IDLE) begin
            slv_ss_n[grant_id] = spi_ss_n;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Randomized scoreboard bench for spi_arbiter; covers SPI_ARB_TIMEOUT_EN when defined.
module tb_spi_arbiter;

    typedef struct {
        int         id;
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  rsp_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        spi_start;
    logic [7:0]  spi_tx_data;
    logic [7:0]  spi_rx_data;
    logic        spi_done;
    logic        spi_ss_n;
    logic [3:0]  slv_ss_n;
`ifdef SPI_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int compared   = 0;
    int mismatched = 0;

    exp_t exp_q[$];
    exp_t e;
    exp_t me;

    // Reference-model state shared between stimulus and monitor
    logic mon_en = 1'b0;
    logic act    = 1'b0;
    int   cur_id = 0;

    int ptr, phase, cnt, cyc, txn, wait_cyc, start_cyc, mode, w;
    logic closing, no_done, reset_done, finished;
    logic [3:0]  rq_snap;
    logic [31:0] dat_snap;
    logic [7:0]  cur_tx;
    logic [3:0]  ess;

    spi_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .rsp_data    (rsp_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_rx_data (spi_rx_data),
        .spi_done    (spi_done),
        .spi_ss_n    (spi_ss_n),
        .slv_ss_n    (slv_ss_n)
`ifdef SPI_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Rotating priority: scan requesters ptr, ptr+1, ... modulo 4
    function automatic int winner(input logic [3:0] r, input int p);
        int c;
        for (int k = 0; k < 4; k++) begin
            c = (p + k) % 4;
            if (r[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic reset_checks();
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_spi_tx_data", 32'(spi_tx_data), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_spi_start", 32'(spi_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_slv_ss_n", 32'(slv_ss_n), 32'hF);
`ifdef SPI_ARB_TIMEOUT_EN
        check("rst_timeout_err", 32'(timeout_err), 0);
`endif
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(busy), 32'(act));
            ess = 4'hF;
            if (act) ess[cur_id[1:0]] = spi_ss_n;
            check("slv_ss_n", 32'(slv_ss_n), 32'(ess));
            if (ack != 4'b0) begin
                if (!act || exp_q.size() == 0) begin
                    check("ack_unexpected", 32'(ack), 0);
                end else begin
                    me = exp_q.pop_front();
                    check("ack", 32'(ack), 32'(4'b0001 << me.id));
                    check("rsp_data", 32'(rsp_data), 32'(me.rx));
                    check("grant_id_hold", 32'(grant_id), 32'(me.id));
                    check("spi_tx_data_hold", 32'(spi_tx_data), 32'(me.tx));
                end
            end
        end
    end

    initial begin
        ptr = 0; phase = 0; cnt = 0; cyc = 0; txn = 0; wait_cyc = 0;
        start_cyc = 0; mode = 0; w = 0;
        closing = 1'b0; no_done = 1'b0; reset_done = 1'b0; finished = 1'b0;
        cur_tx = '0;
        req = '0; req_data = '0; spi_rx_data = '0; spi_done = 1'b0; spi_ss_n = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_checks();
        mon_en = 1'b1;
        req = 4'hF;
        req_data = $urandom;

        while (!finished && cyc < 30000) begin
            @(posedge clk);
            rq_snap  = req;
            dat_snap = req_data;
            #1;
            cyc++;
            spi_done = 1'b0;
            spi_ss_n = 1'($urandom_range(0, 1));

            if (!rst_n) begin
                rst_n = 1'b1;
                reset_checks();
                act = 1'b0; closing = 1'b0; ptr = 0; phase = 0;
                continue;
            end
            if (closing) begin
                act = 1'b0;
                closing = 1'b0;
            end
            if (ack != 4'b0) begin
                req = req & ~ack;
                ptr = (cur_id + 1) % 4;
                closing = 1'b1;
                phase = 0;
                txn++;
                if (mode == 1) begin
                    check("timeout_latency", 32'(cyc - start_cyc), 65);
`ifdef SPI_ARB_TIMEOUT_EN
                    check("timeout_err_set", 32'(timeout_err), 1);
`endif
                    finished = 1'b1;
                end
            end

            if (spi_start) begin
                w = winner(rq_snap, ptr);
                if (act || w < 0) begin
                    check("unexpected_start", 32'(spi_start), 0);
                end else begin
                    check("grant_id", 32'(grant_id), 32'(w));
                    check("spi_tx_data", 32'(spi_tx_data), 32'(dat_snap[w*8 +: 8]));
                    act = 1'b1; cur_id = w; cur_tx = dat_snap[w*8 +: 8];
                    phase = 1; wait_cyc = 0; start_cyc = cyc;
                    cnt = int'($urandom_range(0, 4));
                    if (no_done) begin
                        e.id = w; e.tx = cur_tx; e.rx = 8'hFF;
                        exp_q.push_back(e);
                    end else begin
                        // done during START must be ignored
                        spi_done = 1'b1;
                        spi_rx_data = 8'($urandom);
                    end
                end
            end else if (phase == 1) begin
                wait_cyc++;
                if (!no_done) begin
                    if (txn >= 60 && !reset_done && cnt >= 1) begin
                        rst_n = 1'b0;
                        reset_done = 1'b1;
                    end else if (cnt == 0) begin
                        spi_rx_data = 8'($urandom);
                        spi_done = 1'b1;
                        e.id = cur_id; e.tx = cur_tx; e.rx = spi_rx_data;
                        exp_q.push_back(e);
                        phase = 2;
                    end else begin
                        cnt--;
                    end
                end
            end else if (phase == 2) begin
                wait_cyc++;
            end else if ($urandom_range(0, 3) == 0) begin
                spi_done = 1'b1;
                spi_rx_data = 8'($urandom);
            end

            if (phase != 0 && wait_cyc > 200) begin
                check("ack_watchdog", 32'(wait_cyc), 0);
                finished = 1'b1;
            end

            if (mode == 0) begin
                if (txn < 150) begin
                    for (int i = 0; i < 4; i++) begin
                        if (!req[i] && !ack[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
                    end
                    if ($urandom_range(0, 3) == 0) req_data = $urandom;
                end else if (req == 4'b0 && phase == 0 && !act && !closing) begin
`ifdef SPI_ARB_TIMEOUT_EN
                    check("timeout_err_clear", 32'(timeout_err), 0);
                    mode = 1;
                    no_done = 1'b1;
                    req = 4'b0100;
                    req_data = $urandom;
`else
                    finished = 1'b1;
`endif
                end
            end
        end

        if (!finished) check("run_complete", 32'(finished), 1);
        if (closing) begin
            @(posedge clk);
            #1;
            act = 1'b0;
            closing = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 0);
`ifdef SPI_ARB_TIMEOUT_EN
        check("timeout_err_sticky", 32'(timeout_err), 1);
`endif
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one SPI master (fixed 4 in this revision).
REQ-002 Parameter DATA_W, default 8, SPI frame width.
REQ-003 Parameter TIMEOUT_CYC, default 64, watchdog limit in clk cycles (used only with SPI_ARB_TIMEOUT_EN).
REQ-004 One clock; reset is synchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-005 req  input  NUM_REQ  per-requester transaction request, level, held until ack.
REQ-006 req_data  input  NUM_REQ*DATA_W  packed tx bytes, requester i at bits [i*8+7:i*8].
REQ-007 ack  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-008 rsp_data  output  DATA_W  byte received for the last completed transaction.
REQ-009 grant_id  output  2  index of current/last granted requester.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 spi_start  output  1  start_transaction to SPI master.
REQ-012 spi_tx_data  output  DATA_W  tx_data to SPI master.
REQ-013 spi_rx_data  input  DATA_W  rx_data from SPI master.
REQ-014 spi_done  input  1  transaction_done from SPI master.
REQ-015 spi_ss_n  input  1  ss_n from SPI master.
REQ-016 slv_ss_n  output  NUM_REQ  per-slave selects; bit grant_id follows spi_ss_n, others 1.
REQ-017 timeout_err  output  1  sticky watchdog flag (present only with SPI_ARB_TIMEOUT_EN).

Function
REQ-018 FSM states IDLE, START, BUSY, DONE; registered state.
REQ-019 IDLE: if req != 0, latch winner index into grant_id and its req_data byte into spi_tx_data, go START; else stay.
REQ-020 Winner = first asserted req scanning from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
REQ-021 START: spi_start = 1 for exactly one cycle, go BUSY.
REQ-022 BUSY: on spi_done = 1 latch spi_rx_data into rsp_data, go DONE; else stay.
REQ-023 DONE: ack[grant_id] = 1 for one cycle, rr_ptr <= grant_id+1 mod NUM_REQ, go IDLE.
REQ-024 Grant-to-start latency: req seen in IDLE at cycle N -> spi_start at N+1; ack one cycle after spi_done sample.
REQ-025 spi_tx_data and grant_id stable from START until next IDLE decision; req_data changes after latch ignored.
REQ-026 req deasserted mid-transaction: transaction completes, ack still pulsed.
REQ-027 spi_done outside BUSY ignored; ack never asserted in IDLE/START/BUSY.
REQ-028 Requester that received ack may win again only after all other pending requesters (rr fairness).
REQ-029 slv_ss_n combinational from grant_id and spi_ss_n; all ones when state is IDLE.

Reset
REQ-030 rst_n = 0 at a clk edge: state IDLE, rr_ptr 0, grant_id 0, spi_tx_data 0, rsp_data 0, ack 0, spi_start 0, timeout_err 0.
REQ-031 Reset mid-transaction aborts without ack; slv_ss_n returns to all ones the following cycle.

Configuration
REQ-032 Macro SPI_ARB_TIMEOUT_EN defined: counter runs in BUSY; at TIMEOUT_CYC cycles without spi_done, go DONE with rsp_data = 8'hFF, pulse ack, set timeout_err sticky until reset.
REQ-033 Macro undefined: no counter, no timeout_err port, BUSY waits indefinitely.

Structure
REQ-034 Package spi_arb_pkg: state enum type, NUM_REQ, DATA_W defaults, TIMEOUT_CYC default.
REQ-035 Sub-module spi_rr_picker: combinational round-robin winner (req, rr_ptr -> valid, idx).

Verification
REQ-036 req=4'b0001, req_data[7:0]=8'h99, spi_rx_data=8'h5A on spi_done -> spi_tx_data=8'h99, one spi_start pulse, ack=4'b0001, rsp_data=8'h5A.
REQ-037 req=4'b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0; each ack one cycle.
REQ-038 grant_id=2, spi_ss_n toggles -> slv_ss_n[2] mirrors it, slv_ss_n[0,1,3]=1.
REQ-039 rst_n=0 asserted during BUSY -> no ack, state IDLE, all outputs at reset values next cycle.
REQ-040 With SPI_ARB_TIMEOUT_EN, spi_done never asserted -> ack after 64 BUSY cycles, rsp_data=8'hFF, timeout_err=1 held.
